// File: rtl/mem_readback_unit_if.sv
// Bundles the readback request, data-memory read port and output word stream.
// master is taken by the readback unit; slave is taken by its environment.
interface mem_readback_unit_if #(
   parameter int DATA_WIDTH         = 64,
   parameter int THREAD_INDEX_BITS  = 3,
   parameter int DATA_MEM_ADDR_BITS = 8
);
   logic                                        in_start;
   logic [THREAD_INDEX_BITS-1:0]                in_thread_index;
   logic [DATA_MEM_ADDR_BITS-1:0]               in_base_addr;
   logic [DATA_MEM_ADDR_BITS:0]                 in_word_count;
   logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] out_mem_raddr;
   logic [DATA_WIDTH-1:0]                       in_mem_rdata;
   logic                                        out_valid;
   logic                                        in_ready;
   logic [DATA_WIDTH-1:0]                       out_data;
   logic                                        out_last;
   logic                                        out_busy;
   logic                                        out_done;

   modport master (
      input  in_start, in_thread_index, in_base_addr, in_word_count,
      input  in_mem_rdata, in_ready,
      output out_mem_raddr, out_valid, out_data, out_last, out_busy, out_done
   );

   modport slave (
      output in_start, in_thread_index, in_base_addr, in_word_count,
      output in_mem_rdata, in_ready,
      input  out_mem_raddr, out_valid, out_data, out_last, out_busy, out_done
   );
endinterface

// File: rtl/mem_readback_unit.sv
// Streams a burst of words from one thread's data-memory region; first word valid two edges
// after the accepting edge, one word/cycle; backpressure via in_ready, 2-entry buffer never overflows.
module mem_readback_unit #(
   parameter int DATA_WIDTH         = 64,
   parameter int THREAD_INDEX_BITS  = 3,
   parameter int DATA_MEM_ADDR_BITS = 8
) (
   input logic                 clk,
   input logic                 reset,
   mem_readback_unit_if.master bus
);
   localparam int CNT_W = DATA_MEM_ADDR_BITS + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                        state_q, state_d;
   logic [THREAD_INDEX_BITS-1:0]  thread_q, thread_d;
   logic [DATA_MEM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]              remain_q, remain_d;
   logic                          inflight_q, inflight_d;
   logic                          inflight_last_q, inflight_last_d;
   logic [DATA_WIDTH-1:0]         buf_dat_q [2];
   logic [DATA_WIDTH-1:0]         buf_dat_d [2];
   logic [1:0]                    buf_last_q, buf_last_d;
   logic                          wr_ptr_q, wr_ptr_d;
   logic                          rd_ptr_q, rd_ptr_d;
   logic [1:0]                    cnt_q, cnt_d;
   logic                          done_q, done_d;
   logic                          issue;
   logic                          pop;
   logic                          head_last;
   logic [2:0]                    slots;

   always_comb begin
      state_d         = state_q;
      thread_d        = thread_q;
      addr_d          = addr_q;
      remain_d        = remain_q;
      buf_dat_d       = buf_dat_q;
      buf_last_d      = buf_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      done_d          = 1'b0;
      issue           = 1'b0;
      pop             = (cnt_q != 2'd0) && bus.in_ready;
      head_last       = buf_last_q[rd_ptr_q];
      // Occupancy is counted after this cycle's pop so a steady in_ready sustains full rate.
      slots           = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

      case (state_q)
         IDLE: begin
            if (bus.in_start) begin
               thread_d = bus.in_thread_index;
               addr_d   = bus.in_base_addr;
               remain_d = bus.in_word_count;
               if (bus.in_word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (slots < 3'd2) begin
               issue    = 1'b1;
               addr_d   = addr_q + 1'b1;
               remain_d = remain_q - 1'b1;
               if (remain_q == CNT_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      inflight_d      = issue;
      inflight_last_d = issue && (remain_q == CNT_W'(1));

      // Read data lands exactly one cycle after issue.
      if (inflight_q) begin
         buf_dat_d[wr_ptr_q]  = bus.in_mem_rdata;
         buf_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         thread_q        <= '0;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         buf_dat_q[0]    <= '0;
         buf_dat_q[1]    <= '0;
         buf_last_q      <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         cnt_q           <= '0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         thread_q        <= thread_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         buf_dat_q       <= buf_dat_d;
         buf_last_q      <= buf_last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         cnt_q           <= cnt_d;
         done_q          <= done_d;
      end
   end

   assign bus.out_mem_raddr = {thread_q, addr_q};
   assign bus.out_valid     = (cnt_q != 2'd0);
   assign bus.out_data      = bus.out_valid ? buf_dat_q[rd_ptr_q] : '0;
   assign bus.out_last      = bus.out_valid && head_last;
   assign bus.out_busy      = (state_q != IDLE);
   assign bus.out_done      = done_q;
endmodule

// File: tb/tb_mem_readback_unit.sv
// Directed bench for mem_readback_unit: table of bursts plus start-while-busy and mid-burst reset.
// Memory model returns the read address itself as data, one cycle after the address.
module tb_mem_readback_unit;
   localparam int DW = 64;
   localparam int TB = 3;
   localparam int AB = 8;

   typedef struct {
      logic [2:0]  thread;
      logic [7:0]  base;
      logic [8:0]  count;
      int          mode;
      logic [63:0] exp_first;
      logic [63:0] exp_final;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs [7];

   mem_readback_unit_if #(.DATA_WIDTH(DW), .THREAD_INDEX_BITS(TB), .DATA_MEM_ADDR_BITS(AB)) bus ();

   mem_readback_unit #(.DATA_WIDTH(DW), .THREAD_INDEX_BITS(TB), .DATA_MEM_ADDR_BITS(AB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.in_mem_rdata <= DW'(bus.out_mem_raddr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] exp_word(input vec_t v, input int i);
      logic [7:0] a;
      a = v.base + 8'(i);
      return 64'({v.thread, a});
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_last"},  64'(bus.out_last),  64'd0);
      check({tag, "_busy"},  64'(bus.out_busy),  64'd0);
      check({tag, "_done"},  64'(bus.out_done),  64'd0);
      check({tag, "_data"},  bus.out_data,       64'd0);
      check({tag, "_raddr"}, 64'(bus.out_mem_raddr), 64'd0);
   endtask

   // Called at a negedge; drives in_start in that same cycle.
   task automatic run_burst(input vec_t v, input bit start_while_busy);
      int  n_got = 0;
      int  first_cyc = -1;
      bit  last_seen = 1'b0;
      bit  finished = 1'b0;
      bit  prev_stall = 1'b0;
      logic rdy;
      bus.in_start        = 1'b1;
      bus.in_thread_index = v.thread;
      bus.in_base_addr    = v.base;
      bus.in_word_count   = v.count;
      bus.in_ready        = 1'b1;
      @(negedge clk);
      bus.in_start        = 1'b0;
      bus.in_thread_index = ~v.thread;
      bus.in_base_addr    = ~v.base;
      bus.in_word_count   = 9'd5;
      if (v.count == 9'd0) begin
         check("zero_done",  64'(bus.out_done),  64'd1);
         check("zero_busy",  64'(bus.out_busy),  64'd0);
         check("zero_valid", 64'(bus.out_valid), 64'd0);
         @(negedge clk);
         check("zero_done_pulse", 64'(bus.out_done), 64'd0);
         check("zero_busy_after", 64'(bus.out_busy), 64'd0);
         check("zero_valid_after", 64'(bus.out_valid), 64'd0);
         return;
      end
      for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
         if (last_seen) begin
            check("done_pulse", 64'(bus.out_done),  64'd1);
            check("done_busy",  64'(bus.out_busy),  64'd0);
            check("done_valid", 64'(bus.out_valid), 64'd0);
            finished = 1'b1;
         end else begin
            check("early_done", 64'(bus.out_done), 64'd0);
            check("busy", 64'(bus.out_busy), 64'd1);
            if (bus.out_valid && first_cyc < 0) begin
               first_cyc = cyc;
               check("first_latency", 64'(cyc), 64'd3);
            end
            if (prev_stall) check("stall_valid", 64'(bus.out_valid), 64'd1);
            if (v.mode == 0 && first_cyc > 0) check("no_bubble", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) begin
               check("data", bus.out_data, exp_word(v, n_got));
               check("last", 64'(bus.out_last), 64'(n_got == int'(v.count) - 1));
            end
            case (v.mode)
               0:       rdy = 1'b1;
               2:       rdy = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.in_ready = rdy;
            if (start_while_busy && cyc == 2) begin
               bus.in_start        = 1'b1;
               bus.in_thread_index = 3'd6;
               bus.in_base_addr    = 8'h55;
               bus.in_word_count   = 9'd3;
            end else begin
               bus.in_start = 1'b0;
            end
            if (bus.out_valid && rdy) begin
               if (n_got == 0) check("first_word", bus.out_data, v.exp_first);
               if (n_got == int'(v.count) - 1) begin
                  check("final_word", bus.out_data, v.exp_final);
                  last_seen = 1'b1;
               end
               n_got++;
            end
            prev_stall = bus.out_valid && !rdy;
            @(negedge clk);
         end
      end
      if (!finished) check("burst_timeout", 64'd0, 64'd1);
      check("word_count", 64'(n_got), 64'(v.count));
      bus.in_ready = 1'b1;
      @(negedge clk);
      check("done_once", 64'(bus.out_done), 64'd0);
      check("idle_busy", 64'(bus.out_busy), 64'd0);
      check("idle_valid", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int got;
      vecs[0] = '{3'd2, 8'h10, 9'd4,   0, 64'h210, 64'h213};
      vecs[1] = '{3'd5, 8'hFE, 9'd4,   0, 64'h5FE, 64'h501};
      vecs[2] = '{3'd1, 8'h20, 9'd8,   2, 64'h120, 64'h127};
      vecs[3] = '{3'd7, 8'h00, 9'd1,   1, 64'h700, 64'h700};
      vecs[4] = '{3'd3, 8'hFF, 9'd2,   1, 64'h3FF, 64'h300};
      vecs[5] = '{3'd0, 8'h80, 9'd0,   0, 64'h0,   64'h0};
      vecs[6] = '{3'd4, 8'h00, 9'd256, 0, 64'h400, 64'h4FF};

      bus.in_start        = 1'b0;
      bus.in_thread_index = '0;
      bus.in_base_addr    = '0;
      bus.in_word_count   = '0;
      bus.in_ready        = 1'b0;
      reset               = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");

      reset = 1'b0;
      for (int i = 0; i < 7; i++) run_burst(vecs[i], 1'b0);
      run_burst(vecs[2], 1'b0);
      run_burst(vecs[0], 1'b1);

      // Abort a 10-word burst after three transfers.
      bus.in_start        = 1'b1;
      bus.in_thread_index = 3'd3;
      bus.in_base_addr    = 8'h40;
      bus.in_word_count   = 9'd10;
      bus.in_ready        = 1'b1;
      @(negedge clk);
      bus.in_start = 1'b0;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.out_valid && bus.in_ready) got++;
         @(negedge clk);
         if (got == 3) break;
      end
      check("abort_progress", 64'(got), 64'd3);
      reset = 1'b1;
      @(negedge clk);
      check_idle_zero("mid_reset");
      @(negedge clk);
      check_idle_zero("mid_reset_hold");
      reset = 1'b0;
      run_burst(vecs[1], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_readback_unit.md
MEM_READBACK_UNIT -- requirements
Module: mem_readback_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one data-memory word.
REQ-002 SHALL have parameter THREAD_INDEX_BITS, default 3, thread-index field width.
REQ-003 SHALL have parameter DATA_MEM_ADDR_BITS, default 8, per-thread word-address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port in_start, input, 1, request to begin a readback burst.
REQ-007 SHALL have port in_thread_index, input, THREAD_INDEX_BITS, thread whose memory region is read.
REQ-008 SHALL have port in_base_addr, input, DATA_MEM_ADDR_BITS, first word address within the thread region.
REQ-009 SHALL have port in_word_count, input, DATA_MEM_ADDR_BITS+1, number of words to read (0..2^DATA_MEM_ADDR_BITS).
REQ-010 SHALL have port out_mem_raddr, output, THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS, data-memory read address {thread, word}.
REQ-011 SHALL have port in_mem_rdata, input, DATA_WIDTH, data-memory read data, valid one cycle after out_mem_raddr.
REQ-012 SHALL have port out_valid, input-side handshake output, 1, out_data holds a valid word.
REQ-013 SHALL have port in_ready, input, 1, consumer accepts out_data this cycle.
REQ-014 SHALL have port out_data, output, DATA_WIDTH, streamed memory word.
REQ-015 SHALL have port out_last, output, 1, out_data is the final word of the burst.
REQ-016 SHALL have port out_busy, output, 1, burst in progress.
REQ-017 SHALL have port out_done, output, 1, single-cycle burst-completion pulse.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN; IDLE on reset.
REQ-019 SHALL, in IDLE with in_start=1, latch thread, base address, count; go READ if count>0, else stay IDLE and pulse out_done next cycle with no output words.
REQ-020 SHALL ignore in_start while out_busy=1.
REQ-021 SHALL hold out_busy=1 in READ and DRAIN, 0 in IDLE.
REQ-022 SHALL issue one read per cycle in READ only when (output-buffer occupancy + reads in flight) < 2.
REQ-023 SHALL treat read data as arriving exactly one cycle after issue and write it into a 2-entry FIFO output buffer.
REQ-024 SHALL increment the word address by 1 per issued read, wrapping modulo 2^DATA_MEM_ADDR_BITS; thread bits never change within a burst.
REQ-025 SHALL move READ->DRAIN in the cycle the last read is issued.
REQ-026 SHALL present buffer head on out_data with out_valid=1 whenever buffer non-empty; transfer occurs when out_valid & in_ready.
REQ-027 SHALL hold out_data/out_last stable while out_valid=1 and in_ready=0.
REQ-028 SHALL assert out_last with the word-count'th word only.
REQ-029 SHALL, in DRAIN, return to IDLE and pulse out_done in the cycle after the last-word transfer.
REQ-030 SHALL sustain one word per cycle when in_ready is held high (first word out_valid 2 cycles after in_start).
REQ-031 SHALL handle simultaneous push and pop of the buffer without loss or duplication.
REQ-032 SHALL drive out_mem_raddr from the internal address register at all times (don't-care reads allowed when not issuing).

Reset
REQ-033 SHALL, when reset=1 at a rising edge, force IDLE, empty buffer, clear in-flight tracking, out_valid=0, out_last=0, out_busy=0, out_done=0, out_data=0, out_mem_raddr=0.
REQ-034 SHALL abort any burst on reset mid-operation, with no further words or out_done for it.
REQ-035 SHALL accept in_start in the first cycle after reset deasserts.

Verification
REQ-036 SHALL verify: thread 2, base 0x10, count 4, in_ready=1 -> words 0x210..0x213 on consecutive cycles, out_last on 4th, out_done one cycle later.
REQ-037 SHALL verify: base 0xFE, count 4 -> addresses 0xFE,0xFF,0x00,0x01 within same thread.
REQ-038 SHALL verify: count 8, in_ready toggled randomly/held low 5 cycles -> all 8 words in order, no drops/duplicates, out_data stable while stalled.
REQ-039 SHALL verify: count 0 -> no out_valid, out_done pulse next cycle, out_busy stays 0.
REQ-040 SHALL verify: in_start during busy burst -> ignored, original burst completes unchanged.
REQ-041 SHALL verify: reset asserted after 3 of 10 words -> all outputs zero next cycle, no out_done, new burst afterwards correct.
